// File: rtl/weight_bit_serializer_pkg.sv
// Shared constants and types for the bit-serial weight producer.
// Weights enter as two's complement and leave as sign plus magnitude bit-columns.
package bitsim_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int VEC_LENGTH = 16;
  localparam int COL_BITS   = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  // One weight vector: lane j occupies weight_vec_t[j].
  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_vec_t;
  typedef logic [VEC_LENGTH-1:0]                 lane_vec_t;
  typedef logic [DATA_WIDTH-1:0]                 col_mask_t;
  typedef logic [COL_BITS-1:0]                   col_t;

  // Two's complement to unsigned magnitude; the most negative value maps to 2^(DATA_WIDTH-1).
  function automatic logic [DATA_WIDTH-1:0] mag_of(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1] ? (~w + DATA_WIDTH'(1)) : w;
  endfunction

  // True when some mask bit strictly above column p is set.
  function automatic logic any_above(input col_mask_t m, input col_t p);
    col_mask_t upto;
    upto = (col_mask_t'(2) << p) - col_mask_t'(1);
    return |(m & ~upto);
  endfunction

endpackage

// File: rtl/weight_bit_serializer_if.sv
// Weight-vector input and bit-column beat output of the serializer.
// slave = serializer side, master = producer/consumer side.
interface weight_bit_serializer_if;

  logic                    w_valid;
  logic                    w_ready;
  bitsim_pkg::weight_vec_t weight;
  logic                    out_valid;
  logic                    out_ready;
  bitsim_pkg::lane_vec_t   sign;
  bitsim_pkg::lane_vec_t   w_bit;
  bitsim_pkg::col_t        column_idx;
  logic                    out_first;
  logic                    out_last;

  modport slave (
    input  w_valid, weight, out_ready,
    output w_ready, out_valid, sign, w_bit, column_idx, out_first, out_last
  );

  modport master (
    output w_valid, weight, out_ready,
    input  w_ready, out_valid, sign, w_bit, column_idx, out_first, out_last
  );

endinterface

// File: rtl/weight_bit_serializer_col_next_enc.sv
// Finds the lowest set mask bit strictly above a pointer.
// A pointer of -1 (all ones) returns the lowest set bit of the whole mask.
module col_next_enc
  import bitsim_pkg::*;
(
  input  col_mask_t                i_mask,
  input  logic signed [COL_BITS:0] i_ptr,
  output col_t                     o_next,
  output logic                     o_has_next
);

  // Scan from the top down so the last hit is the lowest qualifying column.
  always_comb begin
    o_next     = '0;
    o_has_next = 1'b0;
    for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
      if (i_mask[c] && (c > int'(i_ptr))) begin
        o_next     = COL_BITS'(c);
        o_has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_bit_serializer.sv
// Bit-serial weight producer: latches a signed weight vector, converts it to
// sign-magnitude and streams one bit-column per beat, LSB column first.
// Build option WEIGHT_BIT_SKIP_EN: skip columns whose magnitude bits are zero in
// every lane (an all-zero vector still yields one beat at column 0).
// Every output except w_ready comes straight from a register.
module weight_bit_serializer
  import bitsim_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  weight_bit_serializer_if.slave bus
);

  ser_state_t  r_state;
  ser_state_t  r_state_next;
  lane_vec_t   r_sign;
  lane_vec_t   r_wbit;
  weight_vec_t r_mag;
  col_mask_t   r_mask;
  col_t        r_ptr;
  logic        r_first;
  logic        r_last;

  logic        w_accept;
  logic        w_beat;
  lane_vec_t   w_sign_new;
  weight_vec_t w_mag_new;
  col_mask_t   w_mask_new;
  col_t        w_low_ptr;
  logic        w_low_has;
  col_t        w_ptr_load;
  logic        w_last_load;
  lane_vec_t   w_wbit_load;
  col_t        w_adv_ptr;
  logic        w_adv_has;
  logic        w_last_adv;
  lane_vec_t   w_wbit_adv;

  // A new vector may enter when idle or when the current last beat is leaving.
  assign bus.w_ready = !reset &&
                       ((r_state == IDLE) || ((r_state == SHIFT) && bus.out_ready && r_last));
  assign w_accept    = bus.w_valid && bus.w_ready;
  assign w_beat      = (r_state == SHIFT) && bus.out_ready;

  // Per-lane sign/magnitude of the incoming vector and the bit each beat presents.
  generate
    for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
      assign w_sign_new[gi]  = bus.weight[gi][DATA_WIDTH-1];
      assign w_mag_new[gi]   = mag_of(bus.weight[gi]);
      assign w_wbit_load[gi] = w_mag_new[gi][w_ptr_load];
      assign w_wbit_adv[gi]  = r_mag[gi][w_adv_ptr];
    end
  endgenerate

`ifdef WEIGHT_BIT_SKIP_EN
  // Column c is worth a beat only if some lane has magnitude bit c set.
  always_comb begin
    w_mask_new = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_mask_new = w_mask_new | w_mag_new[j];
    end
  end
`else
  assign w_mask_new = '1;
`endif

  // Lowest column of the incoming vector.
  col_next_enc u_enc_low (
    .i_mask     (w_mask_new),
    .i_ptr      ({(COL_BITS + 1){1'b1}}),
    .o_next     (w_low_ptr),
    .o_has_next (w_low_has)
  );

  // Column following the one currently on the output.
  col_next_enc u_enc_adv (
    .i_mask     (r_mask),
    .i_ptr      ({1'b0, r_ptr}),
    .o_next     (w_adv_ptr),
    .o_has_next (w_adv_has)
  );

  // An empty mask still produces a single beat at column 0.
  assign w_ptr_load  = w_low_has ? w_low_ptr : '0;
  assign w_last_load = !any_above(w_mask_new, w_ptr_load);
  assign w_last_adv  = !any_above(r_mask, w_adv_ptr);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  // Next state: leave IDLE on accept, return after the last beat unless refilled.
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) r_state_next = SHIFT;
      SHIFT:   if (w_beat && r_last && !w_accept) r_state_next = IDLE;
      default: r_state_next = IDLE;
    endcase
  end

  // Vector storage and beat registers: load on accept, step on each non-last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign  <= '0;
      r_mag   <= '0;
      r_mask  <= '0;
      r_ptr   <= '0;
      r_wbit  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_sign  <= w_sign_new;
      r_mag   <= w_mag_new;
      r_mask  <= w_mask_new;
      r_ptr   <= w_ptr_load;
      r_wbit  <= w_wbit_load;
      r_first <= 1'b1;
      r_last  <= w_last_load;
    end else if (w_beat && !r_last && w_adv_has) begin
      r_ptr   <= w_adv_ptr;
      r_wbit  <= w_wbit_adv;
      r_first <= 1'b0;
      r_last  <= w_last_adv;
    end
  end

  assign bus.out_valid  = (r_state == SHIFT);
  assign bus.sign       = r_sign;
  assign bus.w_bit      = r_wbit;
  assign bus.column_idx = r_ptr;
  assign bus.out_first  = r_first;
  assign bus.out_last   = r_last;

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Self-checking bench for weight_bit_serializer: directed cases plus random
// vectors and random consumer back-pressure, checked against a beat-list model.
// Honours WEIGHT_BIT_SKIP_EN the same way the design does.
module tb_weight_bit_serializer;
  import bitsim_pkg::*;

  typedef struct {
    lane_vec_t sgn;
    lane_vec_t bits;
    int        col;
    bit        first;
    bit        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rnd_en = 1'b0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  weight_bit_serializer_if u_if ();

  weight_bit_serializer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected beat list of one vector, from the sign-magnitude rules.
  function automatic void push_vec(input weight_vec_t v);
    int        mag [VEC_LENGTH];
    lane_vec_t s;
    int        cols[$];
    beat_t     b;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      int x;
      x      = int'($signed(v[j]));
      s[j]   = (x < 0);
      mag[j] = (x < 0) ? -x : x;
    end
    for (int c = 0; c < DATA_WIDTH; c++) begin
      bit any;
      any = 1'b0;
      for (int j = 0; j < VEC_LENGTH; j++) any |= ((mag[j] >> c) & 1) != 0;
`ifdef WEIGHT_BIT_SKIP_EN
      if (any) cols.push_back(c);
`else
      cols.push_back(c);
`endif
    end
    if (cols.size() == 0) cols.push_back(0);
    foreach (cols[k]) begin
      b.sgn   = s;
      for (int j = 0; j < VEC_LENGTH; j++) b.bits[j] = ((mag[j] >> cols[k]) & 1) != 0;
      b.col   = cols[k];
      b.first = (k == 0);
      b.last  = (k == cols.size() - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [63:0] obs_word();
    return 64'({u_if.sign, u_if.w_bit, u_if.column_idx, u_if.out_first, u_if.out_last});
  endfunction

  // Monitor: compare every cycle against the model, then apply this cycle's handshakes.
  initial begin
    beat_t       b;
    logic [63:0] prev_word;
    bit          prev_stall;
    bit          rst_prev;
    bit          exp_ready;
    prev_word  = '0;
    prev_stall = 1'b0;
    rst_prev   = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        check("w_ready_in_reset", 64'(u_if.w_ready), 64'(0));
        if (rst_prev) begin
          check("out_valid_in_reset", 64'(u_if.out_valid), 64'(0));
          check("outputs_in_reset", obs_word(), 64'(0));
        end
        prev_stall = 1'b0;
        rst_prev   = 1'b1;
      end else begin
        rst_prev  = 1'b0;
        exp_ready = (exp_q.size() == 0) || (u_if.out_ready && exp_q[0].last);
        check("w_ready", 64'(u_if.w_ready), 64'(exp_ready));
        check("out_valid", 64'(u_if.out_valid), 64'(exp_q.size() != 0));
        if (prev_stall) check("stall_hold", obs_word(), prev_word);
        if (u_if.out_valid && exp_q.size() != 0) begin
          b = exp_q[0];
          $display("beat col=%0d first=%0b last=%0b sign=%h bits=%h ready=%0b",
                   u_if.column_idx, u_if.out_first, u_if.out_last, u_if.sign, u_if.w_bit, u_if.out_ready);
          check("sign", 64'(u_if.sign), 64'(b.sgn));
          check("w_bit", 64'(u_if.w_bit), 64'(b.bits));
          check("column_idx", 64'(u_if.column_idx), 64'(b.col));
          check("out_first", 64'(u_if.out_first), 64'(b.first));
          check("out_last", 64'(u_if.out_last), 64'(b.last));
        end
        prev_stall = u_if.out_valid && !u_if.out_ready;
        prev_word  = obs_word();
        if (u_if.out_valid && u_if.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (u_if.w_valid && u_if.w_ready) push_vec(u_if.weight);
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) u_if.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Presents v until accepted; leaves w_valid high one step after the accepting edge.
  task automatic send_vec(input weight_vec_t v);
    int n;
    n = 0;
    u_if.weight  = v;
    u_if.w_valid = 1'b1;
    @(negedge clk);
    while (!u_if.w_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'(u_if.w_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || u_if.out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("drain_timeout", 64'(u_if.out_valid), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input int col);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(u_if.out_valid && int'(u_if.column_idx) == col) && n < 50);
    if (n >= 50) check("wait_col_timeout", 64'(u_if.column_idx), 64'(col));
  endtask

  initial begin
    weight_vec_t v;
    weight_vec_t v2;
    reset        = 1'b1;
    u_if.w_valid = 1'b0;
    u_if.weight  = '0;
    u_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(u_if.out_valid), 64'(0));
    check("reset_outputs", obs_word(), 64'(0));
    reset = 1'b0;

    // 1: all lanes +3
    for (int j = 0; j < VEC_LENGTH; j++) v[j] = 8'd3;
    send_vec(v);
    u_if.w_valid = 1'b0;
    wait_drain();

    // 2: lane 0 = -128, rest 0
    v    = '0;
    v[0] = 8'h80;
    send_vec(v);
    u_if.w_valid = 1'b0;
    wait_drain();

`ifdef WEIGHT_BIT_SKIP_EN
    // 3: all-zero vector collapses to one beat
    v = '0;
    send_vec(v);
    u_if.w_valid = 1'b0;
    wait_drain();
`endif

    // 4: back-to-back vectors with w_valid held high
    for (int j = 0; j < VEC_LENGTH; j++) begin
      v[j]  = 8'($urandom);
      v2[j] = 8'($urandom);
    end
    v[0]  = 8'h7F;
    v2[1] = 8'h81;
    send_vec(v);
    send_vec(v2);
    u_if.w_valid = 1'b0;
    wait_drain();

    // 5: three-cycle stall on column 4
    for (int j = 0; j < VEC_LENGTH; j++) v[j] = j[0] ? 8'h80 : 8'h7F;
    send_vec(v);
    u_if.w_valid = 1'b0;
    wait_col(3);
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_col", 64'(u_if.column_idx), 64'(4));
      check("stall_w_ready", 64'(u_if.w_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b1;
    wait_drain();

    // 6: reset in the middle of a vector
    send_vec(v);
    u_if.w_valid = 1'b0;
    wait_col(1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_out_valid", 64'(u_if.out_valid), 64'(0));
    check("midreset_outputs", obs_word(), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int j = 0; j < VEC_LENGTH; j++) v[j] = 8'd3;
    send_vec(v);
    u_if.w_valid = 1'b0;
    wait_drain();

    // Random vectors under random back-pressure
    rnd_en = 1'b1;
    repeat (40) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      v = '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        int x;
        x = int'($urandom_range(0, 6)) - 3;
        if (mode == 0) v[j] = 8'($urandom);
        else if (mode == 1) v[j] = 8'(x);
      end
      if (mode == 2) v[$urandom_range(0, VEC_LENGTH - 1)] = 8'($urandom);
      send_vec(v);
      if ($urandom_range(0, 1) == 1) begin
        u_if.w_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    u_if.w_valid = 1'b0;
    wait_drain();
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
